// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: three-stage IEEE-754 binary adder/subtractor, RNE rounding.
//   Defaults to half precision; EXPW=8/FRACW=23 gives single precision.
//   S1 classifies, orders by magnitude and aligns.
//   S2 adds or subtracts the significands.
//   S3 normalises, rounds and produces the result and flags.
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready = ~out_valid | out_ready
//   in_a, in_b, in_sub   operands {sign, exp, frac}; in_sub=1 computes A-B
//   out_valid/out_ready  output handshake
//   out_result           rounded result
//   out_flags            {NV, OF, UF, NX}, valid while out_valid=1
module fpu_addsub_pipe #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10,
  parameter int W     = 1 + EXPW + FRACW
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);
  // Aligned significand field: implicit bit, fraction, guard, round, sticky.
  localparam int MW  = FRACW + 4;
  localparam int SHW = $clog2(MW + 1);
  localparam logic [EXPW-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]    QNAN     = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};

  function automatic logic [SHW-1:0] lzc(input logic [MW-1:0] v);
    logic [SHW-1:0] n;
    logic           found;
    n     = SHW'(MW);
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = SHW'(MW - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic rneInc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: classify, order, align ----------------
  logic             signA, signB, nanA, nanB, snanA, snanB, infA, infB, aBig;
  logic [EXPW-1:0]  expA, expB, expL, expS, effExpL, effExpS, expDiff;
  logic [FRACW-1:0] fracA, fracB, fracL, fracS;
  logic             signL, signS, nvIn, specIn;
  logic [SHW-1:0]   shAmt;
  logic [2*MW-1:0]  wideS;
  logic [MW-1:0]    alignS;
  logic [W-1:0]     specResIn;

  assign signA = in_a[W-1];
  assign expA  = in_a[W-2:FRACW];
  assign fracA = in_a[FRACW-1:0];
  assign signB = in_b[W-1] ^ in_sub;
  assign expB  = in_b[W-2:FRACW];
  assign fracB = in_b[FRACW-1:0];

  always_comb begin
    nanA  = (expA == EXP_ONES) && (fracA != '0);
    nanB  = (expB == EXP_ONES) && (fracB != '0);
    snanA = nanA && !fracA[FRACW-1];
    snanB = nanB && !fracB[FRACW-1];
    infA  = (expA == EXP_ONES) && (fracA == '0);
    infB  = (expB == EXP_ONES) && (fracB == '0);

    // Magnitude tie keeps A as the larger operand.
    aBig  = in_a[W-2:0] >= in_b[W-2:0];
    signL = aBig ? signA : signB;
    signS = aBig ? signB : signA;
    expL  = aBig ? expA : expB;
    expS  = aBig ? expB : expA;
    fracL = aBig ? fracA : fracB;
    fracS = aBig ? fracB : fracA;

    // Subnormals carry effective exponent 1 with a zero implicit bit.
    effExpL = (expL == '0) ? EXPW'(1) : expL;
    effExpS = (expS == '0) ? EXPW'(1) : expS;
    expDiff = effExpL - effExpS;
    shAmt   = (32'(expDiff) >= MW) ? SHW'(MW) : SHW'(expDiff);

    // Shift through a double-width field so every bit passing the round
    // position lands in the low half and can be ORed into sticky.
    wideS  = {(expS != '0), fracS, 3'b000, {MW{1'b0}}} >> shAmt;
    alignS = {wideS[2*MW-1:MW+1], wideS[MW] | (|wideS[MW-1:0])};

    nvIn   = snanA | snanB | (infA & infB & (signA ^ signB));
    specIn = nanA | nanB | infA | infB;
    if (nanA | nanB | nvIn) specResIn = QNAN;
    else if (infA)          specResIn = {signA, EXP_ONES, {FRACW{1'b0}}};
    else                    specResIn = {signB, EXP_ONES, {FRACW{1'b0}}};
  end

  logic            vld_p1, vld_p2;
  logic            sign_p1, effSub_p1, spec_p1, nv_p1;
  logic [EXPW-1:0] exp_p1;
  logic [MW-1:0]   mantL_p1, mantS_p1;
  logic [W-1:0]    specRes_p1;

  always_ff @(posedge clock) begin
    if (adv) begin
      sign_p1    <= signL;
      effSub_p1  <= signL ^ signS;
      spec_p1    <= specIn;
      nv_p1      <= nvIn;
      exp_p1     <= effExpL;
      mantL_p1   <= {(expL != '0), fracL, 3'b000};
      mantS_p1   <= alignS;
      specRes_p1 <= specResIn;
    end
  end

  // ---------------- S2: significand add/subtract ----------------
  logic [MW:0] sumS2;
  assign sumS2 = effSub_p1 ? ({1'b0, mantL_p1} - {1'b0, mantS_p1})
                           : ({1'b0, mantL_p1} + {1'b0, mantS_p1});

  logic            sign_p2, effSub_p2, spec_p2, nv_p2;
  logic [EXPW-1:0] exp_p2;
  logic [MW:0]     sum_p2;
  logic [W-1:0]    specRes_p2;

  always_ff @(posedge clock) begin
    if (adv) begin
      sign_p2    <= sign_p1;
      effSub_p2  <= effSub_p1;
      spec_p2    <= spec_p1;
      nv_p2      <= nv_p1;
      exp_p2     <= exp_p1;
      sum_p2     <= sumS2;
      specRes_p2 <= specRes_p1;
    end
  end

  // ---------------- S3: normalise, round, flags ----------------
  logic [SHW-1:0]        lz;
  logic [EXPW-1:0]       maxSh, sh, expN, expField;
  logic [MW-1:0]         norm;
  logic                  inc, ovf, nx, resSign;
  logic [EXPW+FRACW:0]   rounded;
  logic [W-1:0]          resS3;
  logic [3:0]            flagsS3;

  always_comb begin
    lz    = lzc(sum_p2[MW-1:0]);
    maxSh = exp_p2 - EXPW'(1);
    sh    = '0;
    if (sum_p2[MW]) begin
      norm = {sum_p2[MW:2], sum_p2[1] | sum_p2[0]};
      expN = exp_p2 + EXPW'(1);
    end else begin
      // Clamp keeps the exponent at 1; a zero top bit then means subnormal.
      sh   = (32'(lz) > 32'(maxSh)) ? maxSh : EXPW'(lz);
      norm = sum_p2[MW-1:0] << sh;
      expN = exp_p2 - sh;
    end
    expField = norm[MW-1] ? expN : '0;

    // Rounding into the packed {exp, frac} lets a mantissa carry bump the
    // exponent, including subnormal -> smallest normal and normal -> overflow.
    inc     = rneInc(norm[3], norm[2], norm[1], norm[0]);
    rounded = {1'b0, expField, norm[MW-2:3]} + (EXPW+FRACW+1)'(inc);
    ovf     = rounded[EXPW+FRACW:FRACW] >= {1'b0, EXP_ONES};
    nx      = norm[2] | norm[1] | norm[0];

    // An exact cancellation yields +0; only an add of two -0 keeps the sign.
    resSign = sign_p2 & ~(effSub_p2 & (sum_p2 == '0));

    if (spec_p2) begin
      resS3   = specRes_p2;
      flagsS3 = {nv_p2, 3'b000};
    end else if (ovf) begin
      resS3   = {resSign, EXP_ONES, {FRACW{1'b0}}};
      flagsS3 = 4'b0101;
    end else begin
      resS3   = {resSign, rounded[EXPW+FRACW-1:0]};
      flagsS3 = {2'b00, (rounded[EXPW+FRACW-1:FRACW] == '0) & nx, nx};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (adv) begin
      vld_p1     <= in_valid;
      vld_p2     <= vld_p1;
      out_valid  <= vld_p2;
      out_result <= resS3;
      out_flags  <= flagsS3;
    end
  end

endmodule

// File: doc/fpu_addsub_pipe.md
Name: fpu_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor. Default format is half precision; the same RTL also covers single precision.
- Three register stages:
  - S1: classify, sort and align.
  - S2: significand add/subtract.
  - S3: normalise and round.
- Valid/ready handshake on both sides.
- Full special-value handling, correct round-to-nearest-even, and four exception flags.
- Intended as the datapath core behind the FPU top-level op dispatcher.

Parameters:
- EXPW, 5, exponent field width.
- FRACW, 10, stored fraction width (no implicit bit).
- W, 1+EXPW+FRACW (derived), operand and result width.

Ports:
- clock input 1 — rising-edge clock.
- reset_n input 1 — asynchronous, active-low reset.
- in_valid input 1 — operands and op presented.
- in_ready output 1 — pipeline can accept this cycle.
- in_a input W — operand A, {sign, exp, frac}.
- in_b input W — operand B.
- in_sub input 1 — 1 computes A−B, 0 computes A+B.
- out_valid output 1 — result valid.
- out_ready input 1 — consumer accepts result.
- out_result output W — rounded result.
- out_flags output 4 — {NV, OF, UF, NX}.

Behaviour:
- Reset (async, reset_n=0): all stage valid bits and out_valid clear to 0. out_result and out_flags clear to 0. Data registers need no reset.
- Advance rule:
  - adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - When adv=1, all stages shift one step together; S1 captures the input and its valid = in_valid.
  - When adv=0, every stage holds.
  - Bubbles are not squeezed.
- Latency and throughput:
  - Latency is exactly 3 cycles from the accepting edge to out_valid, when out_ready stays high.
  - Throughput is 1 op/cycle.
- Ordering: results leave strictly in acceptance order. No op is dropped or duplicated under any out_ready pattern.
- Effective sign of B: b.sign ^ in_sub.
- Operand order: operands are ordered by magnitude {exp, frac}. On a magnitude tie, A is treated as larger.
- Subnormal inputs (exp=0): implicit bit 0, effective exponent 1.
- Alignment:
  - The smaller significand is right-shifted by the exponent difference into a FRACW+4-bit field: implicit bit, fraction, guard, round, sticky.
  - Sticky is the OR of all bits shifted past the round position.
  - Shift amounts ≥ FRACW+3 collapse the operand into sticky only.
- Add/subtract:
  - Magnitude add if the effective signs are equal, otherwise subtract smaller from larger.
  - Result sign is the sign of the larger operand.
- Normalise:
  - On carry-out: right-shift 1, fold the LSB into sticky, exponent +1.
  - Otherwise: left-shift by the leading-zero count, clamped so the exponent does not go below 1. If the clamp is hit, the result is subnormal and the exponent field is 0.
- Rounding: RNE only.
  - Increment iff G & (R | S | LSB).
  - A mantissa carry increments the exponent; a subnormal can round up into the smallest normal.
- Exact-zero result of x−x: +0. Exception: (−0)+(−0) gives −0.
- Overflow: rounded exponent reaching all-ones gives ±inf with OF=1 and NX=1.
- Flag definitions:
  - NX: any of G, R or S nonzero in the final result.
  - UF: result is tiny (exp field 0 after rounding) AND NX.
  - NV: any sNaN input (exp all-ones, frac≠0, frac MSB=0), or inf − inf with effective opposite signs.
- Special values:
  - Any NaN input or NV condition gives canonical qNaN: sign 0, exp all-ones, frac MSB 1, remaining frac bits 0.
  - inf ± finite gives that inf with no flags.
  - inf + inf with the same sign gives inf.
  - Special-value results force OF=UF=NX=0.
- Flag timing: flags are registered alongside out_result in S3 and are valid only when out_valid=1.
- Reset mid-operation: all in-flight ops are discarded. out_valid=0 from the asserting edge. First accept is possible on the first clock edge with reset_n=1.

Test Plan:
- 1+1 and 1−1: 0x3C00 + 0x3C00 → 0x4000, flags 0. 0x3C00 with in_sub=1 and 0x3C00 → 0x0000, flags 0. Each result appears exactly 3 cycles after acceptance.
- RNE tie: 0x3C00 + 0x1000 (exact half ULP) → 0x3C00, NX=1. 0x3C01 + 0x1000 → 0x3C02, NX=1.
- Overflow and specials:
  - 0x7BFF + 0x7BFF → 0x7C00, OF=1, NX=1.
  - 0x7C00 with in_sub=1 and 0x7C00 → 0x7E00, NV=1.
  - 0x7D00 (sNaN) + 0x3C00 → 0x7E00, NV=1.
- Subnormals: 0x0001 + 0x0001 → 0x0002, flags 0. 0x0400 − 0x0001 → 0x03FF, flags 0. 0x3C00 + 0x0001 → 0x3C00, NX=1.
- Backpressure: issue 6 ops back-to-back with out_ready low for cycles 2–7.
  - in_ready must track adv.
  - All 6 results delivered in order with no loss.
  - Payload holds stable while out_valid=1 and out_ready=0.
- Reset mid-flight: assert reset_n=0 with 3 ops in the pipe.
  - out_valid=0 immediately, asynchronous to the clock.
  - After release, a new op 0x4000 + 0x4000 → 0x4400 after 3 cycles.
  - No stale output appears.
